l2_bus_controller: RTL and testbench
====================================

Name: l2_bus_controller

Overview:
- Sequences every shared-bus (FSB) transaction the L2 cache issues: READ, RWIM, WRITE (writeback) and INVALIDATE.
- Sits between the L2 cache storage/output logic and the system bus arbiter, snoop wires and DRAM.
- Per transaction: requests the bus, drives the command phase, samples the snoop window, waits for the data phase, then reports completion and snoop result back to the L2.
- Handles HITM back-off and retry.

Parameters:
- ADDR_W, 32: physical address width.
- SNOOP_WAIT, 2: cycles in the snoop window (must be at least 1).
- MAX_RETRY, 3: HITM retries before the transaction is aborted with error.

Ports:
- clk  in  1  single system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  L2 presents a transaction
- req_ready  out  1  controller can accept; high only in IDLE
- req_op  in  2  00 READ, 01 RWIM, 10 WRITE, 11 INVALIDATE
- req_addr  in  ADDR_W  line address
- bus_req  out  1  request to bus arbiter
- bus_gnt  in  1  grant from arbiter
- bus_cmd_valid  out  1  command phase strobe
- bus_cmd  out  2  opcode on bus (same encoding as req_op)
- bus_addr  out  ADDR_W  address on bus
- snoop_result  in  2  00 NOHIT, 01 HIT, 10 HITM, 11 reserved (treated as NOHIT)
- mem_ready  in  1  data phase complete (DRAM or writeback sink)
- done  out  1  one-cycle completion pulse
- done_snoop  out  2  captured snoop result, valid with done
- done_err  out  1  retry limit exceeded, valid with done

Behaviour:
- One clock; reset is asynchronous and active-low. rst_n low forces state IDLE and clears retry_cnt, snoop timer, latched op/addr and all outputs except req_ready.
- Reset values: bus_req=0, bus_cmd_valid=0, bus_cmd=0, bus_addr=0, done=0, done_snoop=0, done_err=0, req_ready=1. req_ready is decoded from state==IDLE.
- Reset mid-transaction abandons the transaction silently; no done pulse is produced.
- States: IDLE, ARB, CMD, SNOOP, BACKOFF, DATA, DONE.
- IDLE: on req_valid, latch op and addr, set retry_cnt=0, go to ARB. req_valid is ignored in every other state.
- ARB: bus_req=1. When bus_gnt is sampled high, go to CMD. Waits indefinitely.
- CMD: exactly one cycle. bus_cmd_valid=1, bus_cmd=op, bus_addr=addr, bus_req=1. Load snoop timer with SNOOP_WAIT-1, go to SNOOP.
- SNOOP: bus_req=1. Timer decrements each cycle. On the cycle the timer reads 0, sample snoop_result into snp and branch:
  - op=WRITE: go to DATA (snoop ignored, but still reported).
  - op=INVALIDATE: go to DONE (no data phase).
  - op READ/RWIM with HITM and retry_cnt<MAX_RETRY: retry_cnt++, go to BACKOFF.
  - op READ/RWIM with HITM and retry_cnt==MAX_RETRY: set err, go to DONE.
  - Otherwise: go to DATA.
- BACKOFF: bus_req=0 for exactly one cycle so the owning cache can win the bus and write back. Then go to ARB.
- DATA: bus_req=1. When mem_ready is sampled high, go to DONE. mem_ready outside DATA is ignored.
- DONE: bus_req=0. done=1, done_snoop=snp, done_err=err for exactly one cycle. Clear err, go to IDLE.
- bus_gnt is sampled only in ARB. The arbiter must hold the grant while bus_req stays high.
- bus_cmd and bus_addr hold their last values outside CMD. bus_cmd_valid qualifies them.
- Latency, no waits, SNOOP_WAIT=2: accept in cycle 0, ARB in 1, CMD in 2, SNOOP in 3-4, DATA in 5, done in 6.
  - INVALIDATE: done in cycle 5.
  - Each HITM retry adds SNOOP_WAIT+3 cycles minimum (BACKOFF, ARB, CMD, SNOOP).
- retry_cnt width is clog2(MAX_RETRY+1); it never wraps.

Decomposition:
- Package l2_bus_pkg holds:
  - op encodings (OP_READ, OP_RWIM, OP_WRITE, OP_INVAL)
  - snoop encodings (SNP_NOHIT, SNP_HIT, SNP_HITM)
  - state enumeration
- One sub-module, l2_snoop_timer: loadable down-counter with load, enable and zero flag. Width is clog2(SNOOP_WAIT).

Test Plan:
- READ 0x0000_1A40, bus_gnt=1, snoop NOHIT, mem_ready=1 -> one bus_cmd_valid pulse with cmd=00 and addr 0x0000_1A40 in cycle 2; done in cycle 6 with done_snoop=00, done_err=0.
- INVALIDATE 0x0000_2000, snoop HIT -> no DATA state entered, mem_ready ignored; done in cycle 5 with done_snoop=01.
- RWIM with HITM on first snoop, NOHIT on second -> bus_req low for exactly one cycle after the first snoop window, two CMD pulses; done with done_snoop=00, done_err=0.
- READ with HITM on every snoop, MAX_RETRY=3 -> four CMD pulses; done with done_snoop=10, done_err=1.
- bus_gnt held low 10 cycles, mem_ready delayed 5 cycles in DATA, req_valid toggled mid-transaction -> no CMD before grant, done only after mem_ready, extra requests not accepted (req_ready=0).
- rst_n asserted during SNOOP -> all outputs immediately at reset values, no done pulse; a new READ after release completes normally.

Source files
------------

// File: rtl/l2_bus_pkg.sv
// Shared encodings for the L2 front-side-bus controller: opcodes, snoop results, FSM states.
package l2_bus_pkg;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_RWIM  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_INVAL = 2'b11;

    localparam logic [1:0] SNP_NOHIT = 2'b00;
    localparam logic [1:0] SNP_HIT   = 2'b01;
    localparam logic [1:0] SNP_HITM  = 2'b10;

    localparam int unsigned ST_W = 3;
    localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [ST_W-1:0] ST_ARB     = 3'd1;
    localparam logic [ST_W-1:0] ST_CMD     = 3'd2;
    localparam logic [ST_W-1:0] ST_SNOOP   = 3'd3;
    localparam logic [ST_W-1:0] ST_BACKOFF = 3'd4;
    localparam logic [ST_W-1:0] ST_DATA    = 3'd5;
    localparam logic [ST_W-1:0] ST_DONE    = 3'd6;

    // The reserved snoop code behaves exactly like NOHIT.
    function automatic logic [1:0] snp_norm(input logic [1:0] s);
        case (s)
            SNP_NOHIT, SNP_HIT, SNP_HITM: return s;
            default:                      return SNP_NOHIT;
        endcase
    endfunction

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/l2_bus_controller_if.sv
// L2-side request/completion and FSB-side command/snoop/data signals of the bus controller.
interface l2_bus_controller_if #(
    parameter int unsigned ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic              bus_req;
    logic              bus_gnt;
    logic              bus_cmd_valid;
    logic [1:0]        bus_cmd;
    logic [ADDR_W-1:0] bus_addr;
    logic [1:0]        snoop_result;
    logic              mem_ready;
    logic              done;
    logic [1:0]        done_snoop;
    logic              done_err;

    modport slave (
        input  req_valid, req_op, req_addr, bus_gnt, snoop_result, mem_ready,
        output req_ready, bus_req, bus_cmd_valid, bus_cmd, bus_addr,
               done, done_snoop, done_err
    );

    modport master (
        output req_valid, req_op, req_addr, bus_gnt, snoop_result, mem_ready,
        input  req_ready, bus_req, bus_cmd_valid, bus_cmd, bus_addr,
               done, done_snoop, done_err
    );
endinterface

// File: rtl/l2_snoop_timer.sv
// Loadable down-counter timing the snoop window; zero_c flags the sampling cycle.
module l2_snoop_timer #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero_c
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero_c = (cnt == '0);
endmodule

// File: rtl/l2_bus_controller.sv
// Sequences L2 READ/RWIM/WRITE/INVALIDATE transactions on the FSB, including HITM back-off and retry.
module l2_bus_controller
    import l2_bus_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned SNOOP_WAIT = 2,
    parameter int unsigned MAX_RETRY  = 3
) (
    input logic                clk,
    input logic                rst_n,
    l2_bus_controller_if.slave bus
);
    localparam int unsigned TMR_W = cnt_w(SNOOP_WAIT);
    localparam int unsigned RTY_W = cnt_w(MAX_RETRY + 1);

    logic [ST_W-1:0]   state, state_d;
    logic [1:0]        op, op_d;
    logic [ADDR_W-1:0] addr, addr_d;
    logic [RTY_W-1:0]  retry_cnt, retry_d;
    logic              err, err_d;
    logic [1:0]        snp, snp_d;

    logic              bus_req_q, bus_req_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [1:0]        bus_cmd_q, bus_cmd_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic              done_q, done_d;
    logic [1:0]        done_snoop_q, done_snoop_d;
    logic              done_err_q, done_err_d;

    logic              tmr_zero_c;

    l2_snoop_timer #(.W(TMR_W)) u_snoop_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state == ST_CMD),
        .load_val (TMR_W'(SNOOP_WAIT - 1)),
        .en       (state == ST_SNOOP),
        .zero_c   (tmr_zero_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            op           <= OP_READ;
            addr         <= '0;
            retry_cnt    <= '0;
            err          <= 1'b0;
            snp          <= SNP_NOHIT;
            bus_req_q    <= 1'b0;
            cmd_valid_q  <= 1'b0;
            bus_cmd_q    <= 2'b00;
            bus_addr_q   <= '0;
            done_q       <= 1'b0;
            done_snoop_q <= 2'b00;
            done_err_q   <= 1'b0;
        end else begin
            state        <= state_d;
            op           <= op_d;
            addr         <= addr_d;
            retry_cnt    <= retry_d;
            err          <= err_d;
            snp          <= snp_d;
            bus_req_q    <= bus_req_d;
            cmd_valid_q  <= cmd_valid_d;
            bus_cmd_q    <= bus_cmd_d;
            bus_addr_q   <= bus_addr_d;
            done_q       <= done_d;
            done_snoop_q <= done_snoop_d;
            done_err_q   <= done_err_d;
        end
    end

    // Next state plus outputs decoded from the next state so they are registered yet state-aligned.
    always_comb begin
        state_d   = state;
        op_d      = op;
        addr_d    = addr;
        retry_d   = retry_cnt;
        err_d     = err;
        snp_d     = snp;

        case (state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    op_d    = bus.req_op;
                    addr_d  = bus.req_addr;
                    retry_d = '0;
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if (bus.bus_gnt) state_d = ST_CMD;
            end
            ST_CMD: begin
                state_d = ST_SNOOP;
            end
            ST_SNOOP: begin
                if (tmr_zero_c) begin
                    snp_d = snp_norm(bus.snoop_result);
                    case (op)
                        OP_WRITE: state_d = ST_DATA;
                        OP_INVAL: state_d = ST_DONE;
                        OP_READ, OP_RWIM: begin
                            if (snp_d == SNP_HITM) begin
                                if (retry_cnt < RTY_W'(MAX_RETRY)) begin
                                    retry_d = retry_cnt + RTY_W'(1);
                                    state_d = ST_BACKOFF;
                                end else begin
                                    err_d   = 1'b1;
                                    state_d = ST_DONE;
                                end
                            end else begin
                                state_d = ST_DATA;
                            end
                        end
                        default: state_d = ST_DATA;
                    endcase
                end
            end
            ST_BACKOFF: begin
                state_d = ST_ARB;
            end
            ST_DATA: begin
                if (bus.mem_ready) state_d = ST_DONE;
            end
            ST_DONE: begin
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        bus_req_d    = (state_d == ST_ARB) || (state_d == ST_CMD) ||
                       (state_d == ST_SNOOP) || (state_d == ST_DATA);
        cmd_valid_d  = (state_d == ST_CMD);
        bus_cmd_d    = cmd_valid_d ? op_d : bus_cmd_q;
        bus_addr_d   = cmd_valid_d ? addr_d : bus_addr_q;
        done_d       = (state_d == ST_DONE);
        done_snoop_d = done_d ? snp_d : 2'b00;
        done_err_d   = done_d & err_d;
    end

    assign bus.req_ready     = (state == ST_IDLE);
    assign bus.bus_req       = bus_req_q;
    assign bus.bus_cmd_valid = cmd_valid_q;
    assign bus.bus_cmd       = bus_cmd_q;
    assign bus.bus_addr      = bus_addr_q;
    assign bus.done          = done_q;
    assign bus.done_snoop    = done_snoop_q;
    assign bus.done_err      = done_err_q;
endmodule

// File: tb/tb_l2_bus_controller.sv
// Bench for l2_bus_controller: per-transaction cycle schedules built from segment lengths, compared every cycle.
module tb_l2_bus_controller;
    localparam int unsigned AW  = 32;
    localparam int unsigned SW  = 2;
    localparam int unsigned MR  = 3;

    typedef struct {
        logic          rv;
        logic [1:0]    op;
        logic [AW-1:0] ad;
        logic          gnt;
        logic [1:0]    snp;
        logic          mr;
        logic          e_rdy;
        logic          e_req;
        logic          e_cv;
        logic [1:0]    e_cmd;
        logic [AW-1:0] e_addr;
        logic          e_done;
        logic [1:0]    e_ds;
        logic          e_de;
        int            off;
    } cyc_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    l2_bus_controller_if #(.ADDR_W(AW)) bif ();

    l2_bus_controller #(.ADDR_W(AW), .SNOOP_WAIT(SW), .MAX_RETRY(MR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    int errors = 0;
    int checks = 0;
    cyc_t q[$];
    logic [1:0]    last_cmd  = 2'b00;
    logic [AW-1:0] last_addr = '0;
    int done_off, cmd_off, cmd_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Entry for a cycle the controller is busy: L2 noise on req_*, ignored inputs randomized.
    function automatic cyc_t busy_c(input int off);
        cyc_t c;
        c.rv = 1'($urandom); c.op = 2'($urandom); c.ad = AW'($urandom);
        c.gnt = 1'($urandom); c.snp = 2'($urandom); c.mr = 1'($urandom);
        c.e_rdy = 1'b0; c.e_req = 1'b0; c.e_cv = 1'b0;
        c.e_cmd = last_cmd; c.e_addr = last_addr;
        c.e_done = 1'b0; c.e_ds = 2'b00; c.e_de = 1'b0;
        c.off = off;
        return c;
    endfunction

    function automatic cyc_t idle_c();
        cyc_t c;
        c = busy_c(-1);
        c.rv = 1'b0;
        c.e_rdy = 1'b1;
        return c;
    endfunction

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) q.push_back(idle_c());
    endtask

    // Schedule of one transaction: nhitm HITM snoops first, then fin_snp; gw<0 means random grant wait.
    task automatic build_txn(input logic [1:0] op, input logic [AW-1:0] ad, input int nhitm,
                             input logic [1:0] fin_snp, input int gw, input int mw);
        cyc_t c;
        int off = 0;
        int att = 0;
        int g;
        logic [1:0] s, ns;
        logic do_data = 1'b0;
        logic err = 1'b0;
        c = idle_c(); c.rv = 1'b1; c.op = op; c.ad = ad; c.off = off++;
        q.push_back(c);
        for (int a = 0; a <= int'(MR); a++) begin
            g = (gw < 0) ? int'($urandom_range(0, 3)) : gw;
            for (int k = 0; k <= g; k++) begin
                c = busy_c(off++); c.gnt = (k == g); c.e_req = 1'b1; q.push_back(c);
            end
            last_cmd = op; last_addr = ad;
            c = busy_c(off++); c.gnt = 1'b1; c.e_req = 1'b1; c.e_cv = 1'b1;
            c.e_cmd = op; c.e_addr = ad; q.push_back(c);
            s = (att < nhitm) ? 2'b10 : fin_snp;
            for (int k = 0; k < int'(SW); k++) begin
                c = busy_c(off++); c.gnt = 1'b1; c.e_req = 1'b1;
                if (k == int'(SW) - 1) c.snp = s;
                q.push_back(c);
            end
            ns = (s == 2'b11) ? 2'b00 : s;
            if (op == 2'b10) begin
                do_data = 1'b1;
            end else if (op == 2'b11) begin
                do_data = 1'b0;
            end else if (ns == 2'b10) begin
                if (att < int'(MR)) begin
                    q.push_back(busy_c(off++));
                    att++;
                    continue;
                end
                err = 1'b1;
            end else begin
                do_data = 1'b1;
            end
            break;
        end
        if (do_data) begin
            for (int k = 0; k <= mw; k++) begin
                c = busy_c(off++); c.gnt = 1'b1; c.e_req = 1'b1; c.mr = (k == mw); q.push_back(c);
            end
        end
        c = busy_c(off++); c.e_done = 1'b1; c.e_ds = ns; c.e_de = err; q.push_back(c);
    endtask

    function automatic int model_done_off();
        foreach (q[i]) if (q[i].e_done) return q[i].off;
        return -1;
    endfunction

    // Drives each scheduled cycle and compares the DUT against it away from the clock edge.
    task automatic run_q(input int max_n);
        int n = 0;
        while (q.size() > 0 && n < max_n) begin
            cyc_t c;
            c = q.pop_front();
            n++;
            @(posedge clk); #1;
            bif.req_valid = c.rv; bif.req_op = c.op; bif.req_addr = c.ad;
            bif.bus_gnt = c.gnt; bif.snoop_result = c.snp; bif.mem_ready = c.mr;
            @(negedge clk);
            if (c.off == 0) begin cmd_cnt = 0; done_off = -1; cmd_off = -1; end
            if (bif.bus_cmd_valid) begin cmd_cnt++; if (cmd_off < 0) cmd_off = c.off; end
            if (bif.done) done_off = c.off;
            chk("req_ready",     64'(bif.req_ready),     64'(c.e_rdy));
            chk("bus_req",       64'(bif.bus_req),       64'(c.e_req));
            chk("bus_cmd_valid", 64'(bif.bus_cmd_valid), 64'(c.e_cv));
            chk("bus_cmd",       64'(bif.bus_cmd),       64'(c.e_cmd));
            chk("bus_addr",      64'(bif.bus_addr),      64'(c.e_addr));
            chk("done",          64'(bif.done),          64'(c.e_done));
            if (c.e_done) begin
                chk("done_snoop", 64'(bif.done_snoop), 64'(c.e_ds));
                chk("done_err",   64'(bif.done_err),   64'(c.e_de));
            end
        end
        q.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"},  64'(bif.req_ready),     64'd1);
        chk({tag, "_bus_req"},    64'(bif.bus_req),       64'd0);
        chk({tag, "_cmd_valid"},  64'(bif.bus_cmd_valid), 64'd0);
        chk({tag, "_bus_cmd"},    64'(bif.bus_cmd),       64'd0);
        chk({tag, "_bus_addr"},   64'(bif.bus_addr),      64'd0);
        chk({tag, "_done"},       64'(bif.done),          64'd0);
        chk({tag, "_done_snoop"}, 64'(bif.done_snoop),    64'd0);
        chk({tag, "_done_err"},   64'(bif.done_err),      64'd0);
    endtask

    initial begin
        bif.req_valid = 1'b0; bif.req_op = 2'b00; bif.req_addr = '0;
        bif.bus_gnt = 1'b0; bif.snoop_result = 2'b00; bif.mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("por");
        rst_n = 1'b1;

        // READ, no waits: CMD in cycle 2, done in cycle 6.
        add_idle(2);
        build_txn(2'b00, 32'h0000_1A40, 0, 2'b00, 0, 0);
        add_idle(2);
        chk("model_read_done_off", 64'(model_done_off()), 64'd6);
        run_q(1000);
        chk("read_done_off", 64'(done_off), 64'd6);
        chk("read_cmd_off",  64'(cmd_off),  64'd2);
        chk("read_cmd_cnt",  64'(cmd_cnt),  64'd1);

        // INVALIDATE with HIT: no data phase, done in cycle 5.
        build_txn(2'b11, 32'h0000_2000, 0, 2'b01, 0, 0);
        add_idle(1);
        chk("model_inval_done_off", 64'(model_done_off()), 64'd5);
        run_q(1000);
        chk("inval_done_off", 64'(done_off), 64'd5);

        // RWIM: HITM then NOHIT, one back-off cycle, two CMD pulses.
        build_txn(2'b01, 32'h0000_3C80, 1, 2'b00, 0, 0);
        add_idle(1);
        run_q(1000);
        chk("rwim_retry_cmd_cnt",  64'(cmd_cnt),  64'd2);
        chk("rwim_retry_done_off", 64'(done_off), 64'd11);

        // READ with HITM every time: aborted after four CMD pulses.
        build_txn(2'b00, 32'h0000_4440, 9, 2'b10, 0, 0);
        add_idle(1);
        chk("model_abort_done_off", 64'(model_done_off()), 64'd20);
        run_q(1000);
        chk("abort_cmd_cnt",  64'(cmd_cnt),  64'd4);
        chk("abort_done_off", 64'(done_off), 64'd20);

        // Slow grant and slow memory with req_valid noise during the transaction.
        build_txn(2'b00, 32'hDEAD_BEC0, 0, 2'b01, 10, 5);
        add_idle(1);
        run_q(1000);
        chk("slow_cmd_off",  64'(cmd_off),  64'd12);
        chk("slow_done_off", 64'(done_off), 64'd21);

        // Reset in the first SNOOP cycle abandons the READ silently.
        build_txn(2'b00, 32'h0000_5A00, 0, 2'b00, 0, 0);
        run_q(4);
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("midrst");
        bif.req_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("midrst_hold_done",  64'(bif.done),      64'd0);
            chk("midrst_hold_ready", 64'(bif.req_ready), 64'd1);
        end
        rst_n = 1'b1;
        last_cmd = 2'b00; last_addr = '0;
        add_idle(1);
        build_txn(2'b00, 32'h0000_6B40, 0, 2'b00, 0, 0);
        add_idle(1);
        run_q(1000);
        chk("post_rst_done_off", 64'(done_off), 64'd6);

        // Randomized traffic.
        for (int t = 0; t < 150; t++) begin
            logic [1:0] fs;
            int nh;
            add_idle(int'($urandom_range(0, 2)));
            nh = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
            case ($urandom_range(0, 2))
                0: fs = 2'b00;
                1: fs = 2'b01;
                default: fs = 2'b11;
            endcase
            build_txn(2'($urandom), AW'($urandom), nh, fs, -1, int'($urandom_range(0, 3)));
            run_q(1000);
        end
        add_idle(2);
        run_q(1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1);
    end
endmodule
